// File: rtl/ula_pkg.sv
// Shared types and constants for the 6-bit ALU self-test sequencer:
// FSM states, opcode encodings, LFSR taps and the golden result record.
package ula_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } ula_state_e;

  // Arithmetic opcodes (mode 0)
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDN = 3'd2;
  localparam logic [2:0] OP_SUBN = 3'd3;
  localparam logic [2:0] OP_INCA = 3'd4;
  localparam logic [2:0] OP_DECA = 3'd5;
  localparam logic [2:0] OP_INCB = 3'd6;
  localparam logic [2:0] OP_DECB = 3'd7;

  // Logic opcodes (mode 1)
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_NOTA  = 3'd1;
  localparam logic [2:0] OP_NOTB  = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NAND  = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Taps for x^12 + x^11 + x^10 + x^4 + 1 (bits 11, 10, 9, 3)
  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  typedef struct packed {
    logic [5:0] data;
    logic       overflow;
    logic       zero;
  } ula_result_t;

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ula_golden.sv
// Combinational reference model of the 6-bit ALU: (a, b, code, mode) -> result record.
module ula_golden
  import ula_pkg::*;
(
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  input  logic [2:0]  code,
  input  logic        mode,
  output ula_result_t res
);

  logic [6:0] a7;
  logic [6:0] b7;
  logic [6:0] nb7;
  logic [6:0] sum7;
  logic [5:0] lres;
  logic [5:0] data;

  always_comb begin
    a7   = {1'b0, a};
    b7   = {1'b0, b};
    nb7  = {1'b0, ~b};
    sum7 = '0;
    lres = '0;
    data = '0;

    // Arithmetic is done on zero-extended operands so bit 6 is the carry/borrow
    case (code)
      OP_ADD:  sum7 = a7 + b7;
      OP_SUB:  sum7 = a7 - b7;
      OP_ADDN: sum7 = a7 + nb7;
      OP_SUBN: sum7 = a7 - nb7;
      OP_INCA: sum7 = a7 + 7'd1;
      OP_DECA: sum7 = a7 - 7'd1;
      OP_INCB: sum7 = b7 + 7'd1;
      OP_DECB: sum7 = b7 - 7'd1;
      default: sum7 = '0;
    endcase

    case (code)
      OP_AND:   lres = a & b;
      OP_NOTA:  lres = ~a;
      OP_NOTB:  lres = ~b;
      OP_OR:    lres = a | b;
      OP_XOR:   lres = a ^ b;
      OP_NAND:  lres = ~(a & b);
      OP_PASSA: lres = a;
      OP_PASSB: lres = b;
      default:  lres = '0;
    endcase

    data         = (mode == MODE_LOGIC) ? lres : sum7[5:0];
    res.data     = data;
    res.overflow = (mode == MODE_LOGIC) ? 1'b0 : sum7[6];
    res.zero     = (data == 6'd0);
  end

endmodule

// File: rtl/ula_vector_driver.sv
// Self-test sequencer for the 6-bit ALU: issues LFSR-generated vectors, checks
// responses against ula_golden, counts pass/fail. Optional macro STOP_ON_FAIL_EN.
module ula_vector_driver
  import ula_pkg::*;
#(
  parameter int          NUM_VEC = 16,
  parameter logic [11:0] SEED    = 12'hACE,
  parameter int          TIMEOUT = 64
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [5:0] op_a,
  output logic [5:0] op_b,
  output logic [2:0] op_code,
  output logic       op_mode,
  input  logic       res_valid,
  input  logic [5:0] res_data,
  input  logic       res_overflow,
  input  logic       res_zero,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] first_fail_idx,
  output logic       timeout_flag,
  output ula_state_e dbg_state
);

  // Handshakes: the op channel transfers on any CLOCK_50 edge with op_valid && op_ready,
  // and the payload is held from op_valid rising until that edge. The res channel is
  // valid-only: res_valid is a one-cycle pulse, accepted only while in ST_WAIT.

  localparam int         TCNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

  ula_state_e  state_q, state_d;
  logic [11:0] lfsr_q, lfsr_d;
  logic [7:0]  idx_q, idx_d;
  logic        op_valid_q, op_valid_d;
  logic [5:0]  op_a_q, op_a_d;
  logic [5:0]  op_b_q, op_b_d;
  logic [2:0]  op_code_q, op_code_d;
  logic        op_mode_q, op_mode_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  fail_q, fail_d;
  logic [7:0]  ffi_q, ffi_d;
  logic        tflag_q, tflag_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic        tout_q, tout_d;
  ula_result_t cap_q, cap_d;

  ula_result_t gold;
  logic        vec_fail;
  logic        stop;
  logic [11:0] lfsr_next;
  logic [7:0]  idx_next;

  ula_golden u_golden (
    .a    (op_a_q),
    .b    (op_b_q),
    .code (op_code_q),
    .mode (op_mode_q),
    .res  (gold)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    idx_d      = idx_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_code_d  = op_code_q;
    op_mode_d  = op_mode_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ffi_d      = ffi_q;
    tflag_d    = tflag_q;
    tcnt_d     = tcnt_q;
    tout_d     = tout_q;
    cap_d      = cap_q;
    vec_fail   = 1'b0;
    stop       = 1'b0;
    lfsr_next  = lfsr_step(lfsr_q);
    idx_next   = idx_q + 8'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ISSUE;
          lfsr_d     = SEED;
          idx_d      = 8'd0;
          pass_d     = 8'd0;
          fail_d     = 8'd0;
          ffi_d      = 8'hFF;
          tflag_d    = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          // Payload loaded here so op_valid is up one cycle after start
          op_valid_d = 1'b1;
          op_a_d     = SEED[5:0];
          op_b_d     = SEED[11:6];
          op_code_d  = 3'd0;
          op_mode_d  = 1'b0;
        end
      end

      ST_ISSUE: begin
        if (op_valid_q && op_ready) begin
          op_valid_d = 1'b0;
          state_d    = ST_WAIT;
          tcnt_d     = '0;
          tout_d     = 1'b0;
        end
      end

      ST_WAIT: begin
        if (res_valid) begin
          cap_d.data     = res_data;
          cap_d.overflow = res_overflow;
          cap_d.zero     = res_zero;
          state_d        = ST_CHECK;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          tflag_d = 1'b1;
          tout_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_CHECK: begin
        // A timed-out vector is failed without looking at the stale capture
        vec_fail = tout_q || (cap_q != gold);
        if (vec_fail) begin
          fail_d = sat_inc8(fail_q);
          if (ffi_q == 8'hFF) ffi_d = idx_q;
        end else begin
          pass_d = sat_inc8(pass_q);
        end

`ifdef STOP_ON_FAIL_EN
        stop = (idx_q == LAST_IDX) || vec_fail;
        if (!vec_fail) begin
          lfsr_d = lfsr_next;
          idx_d  = idx_next;
        end
`else
        stop   = (idx_q == LAST_IDX);
        lfsr_d = lfsr_next;
        idx_d  = idx_next;
`endif

        if (stop) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_ISSUE;
          op_valid_d = 1'b1;
          op_a_d     = lfsr_next[5:0];
          op_b_d     = lfsr_next[11:6];
          op_code_d  = idx_next[2:0];
          op_mode_d  = idx_next[3];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      idx_q      <= 8'd0;
      op_valid_q <= 1'b0;
      op_a_q     <= 6'd0;
      op_b_q     <= 6'd0;
      op_code_q  <= 3'd0;
      op_mode_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 8'd0;
      fail_q     <= 8'd0;
      ffi_q      <= 8'hFF;
      tflag_q    <= 1'b0;
      tcnt_q     <= '0;
      tout_q     <= 1'b0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_code_q  <= op_code_d;
      op_mode_q  <= op_mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ffi_q      <= ffi_d;
      tflag_q    <= tflag_d;
      tcnt_q     <= tcnt_d;
      tout_q     <= tout_d;
      cap_q      <= cap_d;
    end
  end

  assign op_valid       = op_valid_q;
  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign op_code        = op_code_q;
  assign op_mode        = op_mode_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign timeout_flag   = tflag_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ula_vector_driver.sv
// Bench for ula_vector_driver: a cycle-level ALU responder, a request-payload
// scoreboard fed from an LFSR model, and end-of-run counter checks.
module tb_ula_vector_driver;
  import ula_pkg::*;

  localparam int          NUM_VEC_P = 16;
  localparam logic [11:0] SEED_P    = 12'hACE;
  localparam int          TIMEOUT_P = 8;
  localparam int          BUDGET    = 2000;

  logic       CLOCK_50;
  logic       reset;
  logic       start;
  logic       op_valid;
  logic       op_ready;
  logic [5:0] op_a;
  logic [5:0] op_b;
  logic [2:0] op_code;
  logic       op_mode;
  logic       res_valid;
  logic [5:0] res_data;
  logic       res_overflow;
  logic       res_zero;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [7:0] first_fail_idx;
  logic       timeout_flag;
  ula_state_e dbg_state;

  logic [5:0]  g_a;
  logic [5:0]  g_b;
  logic [2:0]  g_code;
  logic        g_mode;
  ula_result_t g_res;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];

  // Results of the most recent drive_run
  int drv_xfers;
  int drv_first_lat;
  int drv_first_xfer;
  int drv_stall_seen;
  int drv_timeout_negs;
  bit drv_reset_hit;

  ula_vector_driver #(
    .NUM_VEC (NUM_VEC_P),
    .SEED    (SEED_P),
    .TIMEOUT (TIMEOUT_P)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .start          (start),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_code        (op_code),
    .op_mode        (op_mode),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_overflow   (res_overflow),
    .res_zero       (res_zero),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .timeout_flag   (timeout_flag),
    .dbg_state      (dbg_state)
  );

  ula_golden u_gold (
    .a    (g_a),
    .b    (g_b),
    .code (g_code),
    .mode (g_mode),
    .res  (g_res)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // ---------------- reference models ----------------
  function automatic logic [11:0] tb_lfsr(input logic [11:0] l);
    logic fb;
    fb = l[11] ^ l[10] ^ l[9] ^ l[3];
    return {l[10:0], fb};
  endfunction

  // Returns {overflow, zero, data[5:0]}
  function automatic logic [7:0] tb_model(input logic [5:0] a, input logic [5:0] b,
                                          input logic [2:0] code, input logic mode);
    int ai;
    int bi;
    int r;
    logic [5:0] d;
    logic ov;
    ai = int'(a);
    bi = int'(b);
    if (!mode) begin
      case (code)
        3'd0:    r = ai + bi;
        3'd1:    r = ai - bi;
        3'd2:    r = ai + (63 - bi);
        3'd3:    r = ai - (63 - bi);
        3'd4:    r = ai + 1;
        3'd5:    r = ai - 1;
        3'd6:    r = bi + 1;
        default: r = bi - 1;
      endcase
      r  = r & 127;
      d  = 6'(r & 63);
      ov = (r >= 64);
    end else begin
      case (code)
        3'd0:    r = ai & bi;
        3'd1:    r = 63 - ai;
        3'd2:    r = 63 - bi;
        3'd3:    r = ai | bi;
        3'd4:    r = ai ^ bi;
        3'd5:    r = 63 - (ai & bi);
        3'd6:    r = ai;
        default: r = bi;
      endcase
      d  = 6'(r);
      ov = 1'b0;
    end
    return {ov, (d == 6'd0), d};
  endfunction

  // ---------------- driver / responder ----------------
  // Negative index disables a behaviour. All driving happens on negedge.
  task automatic drive_run(input int corrupt_idx, input int drop_idx, input int stall_idx,
                           input int stall_len, input int junk_idx, input int busy_start_idx,
                           input int reset_idx);
    logic [11:0] l;
    logic [7:0]  iv;
    logic [7:0]  resp;
    logic [15:0] cur;
    logic [15:0] held;
    logic [15:0] exp_word;
    int  stall_left;
    int  cyc;
    int  drop_negs;
    bit  resp_due;
    bit  dropping;

    exp_q.delete();
    l = SEED_P;
    for (int i = 0; i < NUM_VEC_P; i++) begin
      iv = 8'(i);
      exp_q.push_back({iv[3], iv[2:0], l[11:6], l[5:0]});
      l = tb_lfsr(l);
    end

    drv_xfers        = 0;
    drv_first_lat    = -1;
    drv_first_xfer   = -1;
    drv_stall_seen   = 0;
    drv_timeout_negs = -1;
    drv_reset_hit    = 1'b0;
    stall_left       = stall_len;
    resp_due         = 1'b0;
    dropping         = 1'b0;
    drop_negs        = 0;
    held             = '0;
    resp             = '0;

    @(negedge CLOCK_50);
    start = 1'b1;
    cyc   = 0;
    while (cyc < BUDGET) begin
      @(negedge CLOCK_50);
      cyc++;
      start     = 1'b0;
      res_valid = 1'b0;
      op_ready  = 1'b1;
      if (drv_first_lat < 0 && op_valid) drv_first_lat = cyc;
      if (dropping) begin
        drop_negs++;
        if (timeout_flag) begin
          drv_timeout_negs = drop_negs;
          dropping = 1'b0;
        end
      end
      if (done) break;
      if (resp_due) begin
        resp_due = 1'b0;
        if (drv_xfers - 1 == reset_idx) begin
          reset = 1'b1;
          drv_reset_hit = 1'b1;
          break;
        end
        res_valid = 1'b1;
        {res_overflow, res_zero, res_data} = resp;
      end
      if (op_valid) begin
        cur = {op_mode, op_code, op_b, op_a};
        if (drv_xfers == stall_idx && stall_left > 0) begin
          op_ready = 1'b0;
          if (stall_left == stall_len) held = cur;
          tests_run++;
          if (cur !== held) begin
            tests_failed++;
            $display("FAIL stall_payload cyc %0d: got %h expected %h", cyc, cur, held);
          end
          drv_stall_seen++;
          stall_left--;
        end else begin
          if (drv_first_xfer < 0) drv_first_xfer = cyc;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL payload extra transfer: got %h expected none", cur);
          end else begin
            exp_word = exp_q.pop_front();
            if (cur !== exp_word) begin
              tests_failed++;
              $display("FAIL payload vec %0d: got %h expected %h", drv_xfers, cur, exp_word);
            end
          end
          resp = tb_model(op_a, op_b, op_code, op_mode);
          if (drv_xfers == corrupt_idx) resp[0] = ~resp[0];
          if (drv_xfers == junk_idx) begin
            // Response in the transfer cycle itself must be ignored
            res_valid = 1'b1;
            {res_overflow, res_zero, res_data} = ~resp;
          end
          if (drv_xfers == busy_start_idx) start = 1'b1;
          if (drv_xfers == drop_idx) begin
            dropping  = 1'b1;
            drop_negs = 0;
          end else begin
            resp_due = 1'b1;
          end
          drv_xfers++;
        end
      end
    end
    res_valid = 1'b0;
    if (cyc >= BUDGET) begin
      tests_run++;
      tests_failed++;
      $display("FAIL run_budget: got no done after %0d cycles, expected done", cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    tests_run++;
    if ({op_valid, busy, done, timeout_flag} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {op_valid, busy, done, timeout_flag});
    end
    tests_run++;
    if ({pass_cnt, fail_cnt, first_fail_idx} !== {8'd0, 8'd0, 8'hFF}) begin
      tests_failed++; $display("FAIL reset_counters: got %h expected 0000ff", {pass_cnt, fail_cnt, first_fail_idx});
    end
    tests_run++;
    if ({op_a, op_b, op_code, op_mode} !== 16'd0) begin
      tests_failed++; $display("FAIL reset_payload: got %h expected 0000", {op_a, op_b, op_code, op_mode});
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_golden_spot;
    logic [7:0] exp_r;
    g_a = 6'd63; g_b = 6'd1; g_code = 3'd0; g_mode = 1'b0;
    #1;
    tests_run++;
    if ({g_res.overflow, g_res.zero, g_res.data} !== {1'b1, 1'b1, 6'd0}) begin
      tests_failed++; $display("FAIL golden_add_63_1: got %h expected %h", {g_res.overflow, g_res.zero, g_res.data}, {2'b11, 6'd0});
    end
    g_a = 6'd5; g_b = 6'd3; g_code = 3'd4; g_mode = 1'b1;
    #1;
    tests_run++;
    if ({g_res.overflow, g_res.zero, g_res.data} !== {1'b0, 1'b0, 6'd6}) begin
      tests_failed++; $display("FAIL golden_xor_5_3: got %h expected %h", {g_res.overflow, g_res.zero, g_res.data}, {2'b00, 6'd6});
    end
    for (int i = 0; i < 16; i++) begin
      g_a    = 6'($urandom_range(0, 63));
      g_b    = 6'($urandom_range(0, 63));
      g_code = 3'(i % 8);
      g_mode = 1'(i / 8);
      #1;
      exp_r = tb_model(g_a, g_b, g_code, g_mode);
      tests_run++;
      if ({g_res.overflow, g_res.zero, g_res.data} !== exp_r) begin
        tests_failed++;
        $display("FAIL golden_rand a=%0d b=%0d code=%0d mode=%0d: got %h expected %h",
                 g_a, g_b, g_code, g_mode, {g_res.overflow, g_res.zero, g_res.data}, exp_r);
      end
    end
  endtask

  task automatic test_ideal;
    drive_run(-1, -1, -1, 0, -1, -1, -1);
    tests_run++;
    if (drv_first_lat != 1) begin tests_failed++; $display("FAIL ideal_start_latency: got %0d expected 1", drv_first_lat); end
    tests_run++;
    if (drv_xfers != NUM_VEC_P) begin tests_failed++; $display("FAIL ideal_xfers: got %0d expected %0d", drv_xfers, NUM_VEC_P); end
    tests_run++;
    if ({pass_cnt, fail_cnt} !== {8'd16, 8'd0}) begin tests_failed++; $display("FAIL ideal_counts: got pass %0d fail %0d expected 16 0", pass_cnt, fail_cnt); end
    tests_run++;
    if ({done, busy, timeout_flag, first_fail_idx} !== {3'b100, 8'hFF}) begin
      tests_failed++; $display("FAIL ideal_status: got %b %b %b %h expected 1 0 0 ff", done, busy, timeout_flag, first_fail_idx);
    end
  endtask

  task automatic test_stall;
    drive_run(-1, -1, 0, 10, -1, -1, -1);
    tests_run++;
    if (drv_stall_seen != 10) begin tests_failed++; $display("FAIL stall_valid_cycles: got %0d expected 10", drv_stall_seen); end
    tests_run++;
    if (drv_first_xfer != 11) begin tests_failed++; $display("FAIL stall_xfer_cycle: got %0d expected 11", drv_first_xfer); end
    tests_run++;
    if ({pass_cnt, fail_cnt} !== {8'd16, 8'd0}) begin tests_failed++; $display("FAIL stall_counts: got pass %0d fail %0d expected 16 0", pass_cnt, fail_cnt); end
  endtask

  // Starts from DONE of the previous run, so it also covers restart and counter clearing
  task automatic test_back_to_back_corrupt;
    int exp_pass;
    int exp_xfers;
`ifdef STOP_ON_FAIL_EN
    exp_pass  = 3;
    exp_xfers = 4;
`else
    exp_pass  = 15;
    exp_xfers = 16;
`endif
    drive_run(3, -1, -1, 0, -1, -1, -1);
    tests_run++;
    if (drv_xfers != exp_xfers) begin tests_failed++; $display("FAIL corrupt_xfers: got %0d expected %0d", drv_xfers, exp_xfers); end
    tests_run++;
    if (pass_cnt !== 8'(exp_pass)) begin tests_failed++; $display("FAIL corrupt_pass: got %0d expected %0d", pass_cnt, exp_pass); end
    tests_run++;
    if (fail_cnt !== 8'd1) begin tests_failed++; $display("FAIL corrupt_fail: got %0d expected 1", fail_cnt); end
    tests_run++;
    if (first_fail_idx !== 8'd3) begin tests_failed++; $display("FAIL corrupt_first_idx: got %0d expected 3", first_fail_idx); end
    tests_run++;
    if ({done, timeout_flag} !== 2'b10) begin tests_failed++; $display("FAIL corrupt_status: got %b expected 10", {done, timeout_flag}); end
  endtask

  task automatic test_timeout;
    int exp_pass;
    int exp_xfers;
`ifdef STOP_ON_FAIL_EN
    exp_pass  = 5;
    exp_xfers = 6;
`else
    exp_pass  = 15;
    exp_xfers = 16;
`endif
    drive_run(-1, 5, -1, 0, -1, -1, -1);
    // Flag registers at the edge ending the TIMEOUT-th WAIT cycle: TIMEOUT+1 negedges after the transfer negedge
    tests_run++;
    if (drv_timeout_negs != TIMEOUT_P + 1) begin
      tests_failed++; $display("FAIL timeout_latency: got %0d expected %0d", drv_timeout_negs, TIMEOUT_P + 1);
    end
    tests_run++;
    if (timeout_flag !== 1'b1) begin tests_failed++; $display("FAIL timeout_flag: got %b expected 1", timeout_flag); end
    tests_run++;
    if ({pass_cnt, fail_cnt} !== {8'(exp_pass), 8'd1}) begin
      tests_failed++; $display("FAIL timeout_counts: got pass %0d fail %0d expected %0d 1", pass_cnt, fail_cnt, exp_pass);
    end
    tests_run++;
    if (drv_xfers != exp_xfers) begin tests_failed++; $display("FAIL timeout_xfers: got %0d expected %0d", drv_xfers, exp_xfers); end
  endtask

  task automatic test_reset_mid_run;
    drive_run(-1, -1, -1, 0, 1, 2, 7);
    tests_run++;
    if (!drv_reset_hit) begin tests_failed++; $display("FAIL midreset_reached: got 0 expected 1"); end
    tests_run++;
    if ({dbg_state, busy, pass_cnt} !== {ST_WAIT, 1'b1, 8'd7}) begin
      tests_failed++; $display("FAIL midreset_pre: got state %0d busy %b pass %0d expected 2 1 7", dbg_state, busy, pass_cnt);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    tests_run++;
    if ({op_valid, busy, done} !== 3'b000) begin tests_failed++; $display("FAIL midreset_flags: got %b expected 000", {op_valid, busy, done}); end
    tests_run++;
    if ({pass_cnt, fail_cnt, first_fail_idx} !== {8'd0, 8'd0, 8'hFF}) begin
      tests_failed++; $display("FAIL midreset_counters: got %h expected 0000ff", {pass_cnt, fail_cnt, first_fail_idx});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    res_data     = 6'd0;
    res_overflow = 1'b0;
    res_zero     = 1'b0;
    g_a          = 6'd0;
    g_b          = 6'd0;
    g_code       = 3'd0;
    g_mode       = 1'b0;

    test_reset();
    test_golden_spot();
    test_ideal();
    test_stall();
    test_back_to_back_corrupt();
    test_timeout();
    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
